// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one enable-stalled, pipelined rotate-mode CORDIC between
// NUM_CH sample streams. Optional packet locking: define CORDIC_RR_PKT_LOCK_EN.
module cordic_rr_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int BITWIDTH = 24,
    parameter int ZWIDTH   = 24,
    parameter int LATENCY  = 21
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*BITWIDTH-1:0]   s_x,
    input  logic [NUM_CH*BITWIDTH-1:0]   s_y,
    input  logic [NUM_CH*ZWIDTH-1:0]     s_z,
    input  logic [NUM_CH-1:0]            s_last,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    output logic                         cordic_enable,
    output logic                         cordic_strobe_in,
    output logic                         cordic_last_in,
    output logic [BITWIDTH-1:0]          cordic_xi,
    output logic [BITWIDTH-1:0]          cordic_yi,
    output logic [ZWIDTH-1:0]            cordic_zi,
    input  logic                         cordic_strobe_out,
    input  logic                         cordic_last_out,
    input  logic [BITWIDTH-1:0]          cordic_xo,
    input  logic [BITWIDTH-1:0]          cordic_yo,
    input  logic [ZWIDTH-2:0]            cordic_zo,
    output logic [BITWIDTH-1:0]          m_x,
    output logic [BITWIDTH-1:0]          m_y,
    output logic                         m_last,
    output logic [$clog2(NUM_CH)-1:0]    m_chan,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         idle
);
    localparam int CW = $clog2(NUM_CH);
    localparam int NW = $clog2(LATENCY + 1);

    // Handshake semantics: a beat transfers on a cycle where valid & ready are both high;
    // ready never depends on valid of the same port except through the arbiter grant.
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  ptr_next;
    logic           grant_found;
    logic           handshake;
    logic           result_pop;
    logic [LATENCY-1:0] tag_valid;
    logic [CW-1:0]  tag_chan [LATENCY];
    logic [NW-1:0]  inflight;
    logic           unused_zo;

`ifdef CORDIC_RR_PKT_LOCK_EN
    logic           pkt_locked;
    logic [CW-1:0]  lock_chan;
`endif

    assign unused_zo     = ^cordic_zo;
    assign m_valid       = cordic_strobe_out;
    assign m_x           = cordic_xo;
    assign m_y           = cordic_yo;
    assign m_last        = cordic_last_out;
    assign m_chan        = tag_chan[LATENCY-1];
    assign cordic_enable = ~(cordic_strobe_out & ~m_ready);
    assign result_pop    = cordic_strobe_out & m_ready;

    always_comb begin : grant_search
        logic [CW:0] cand;
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(i);
            if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
            if (!grant_found && s_valid[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant       = cand[CW-1:0];
            end
        end
`ifdef CORDIC_RR_PKT_LOCK_EN
        // A packet in progress owns the CORDIC until its last beat, even while it idles.
        if (pkt_locked) begin
            grant_found = s_valid[lock_chan];
            grant       = lock_chan;
        end
`endif
    end

    assign handshake        = grant_found & cordic_enable & ~reset;
    assign cordic_strobe_in = handshake;
    assign ptr_next         = (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        s_ready        = '0;
        cordic_xi      = '0;
        cordic_yi      = '0;
        cordic_zi      = '0;
        cordic_last_in = 1'b0;
        if (handshake) s_ready[grant] = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_found && !reset && grant == CW'(i)) begin
                cordic_xi      = s_x[i*BITWIDTH +: BITWIDTH];
                cordic_yi      = s_y[i*BITWIDTH +: BITWIDTH];
                cordic_zi      = s_z[i*ZWIDTH +: ZWIDTH];
                cordic_last_in = s_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
`ifdef CORDIC_RR_PKT_LOCK_EN
        end else if (handshake && s_last[grant]) begin
`else
        end else if (handshake) begin
`endif
            rr_ptr <= ptr_next;
        end
    end

`ifdef CORDIC_RR_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_locked <= 1'b0;
            lock_chan  <= '0;
        end else if (handshake) begin
            pkt_locked <= ~s_last[grant];
            lock_chan  <= grant;
        end
    end
`endif

    // Channel tags ride alongside the CORDIC and freeze with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            for (int i = 0; i < LATENCY; i++) tag_chan[i] <= '0;
        end else if (cordic_enable) begin
            tag_valid   <= {tag_valid[LATENCY-2:0], handshake};
            tag_chan[0] <= grant;
            for (int i = 1; i < LATENCY; i++) tag_chan[i] <= tag_chan[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({handshake, result_pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == '0) & ~|s_valid;

`ifndef SYNTHESIS
    tag_sync_a: assert property (@(posedge clk) disable iff (reset)
                                 tag_valid[LATENCY-1] == cordic_strobe_out)
        else $error("tag line valid bit out of step with cordic_strobe_out");
`endif

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler with an enable-stalled pass-through CORDIC model, a reference
// arbiter and an expected-result queue.
module tb_cordic_rr_scheduler;
    localparam int NUM_CH = 4;
    localparam int BW     = 24;
    localparam int ZW     = 24;
    localparam int L      = 21;
    localparam int CW     = 2;
    localparam int EW     = CW + 1 + BW + BW;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_CH*BW-1:0]  s_x, s_y;
    logic [NUM_CH*ZW-1:0]  s_z;
    logic [NUM_CH-1:0]     s_last;
    logic [NUM_CH-1:0]     s_valid = '0;
    logic [NUM_CH-1:0]     s_ready;
    logic                  cordic_enable, cordic_strobe_in, cordic_last_in;
    logic [BW-1:0]         cordic_xi, cordic_yi;
    logic [ZW-1:0]         cordic_zi;
    logic                  cordic_strobe_out, cordic_last_out;
    logic [BW-1:0]         cordic_xo, cordic_yo;
    logic [ZW-2:0]         cordic_zo;
    logic [BW-1:0]         m_x, m_y;
    logic                  m_last, m_valid, idle;
    logic [CW-1:0]         m_chan;
    logic                  m_ready = 1'b1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cordic_rr_scheduler #(.NUM_CH(NUM_CH), .BITWIDTH(BW), .ZWIDTH(ZW), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .cordic_enable(cordic_enable), .cordic_strobe_in(cordic_strobe_in),
        .cordic_last_in(cordic_last_in), .cordic_xi(cordic_xi), .cordic_yi(cordic_yi),
        .cordic_zi(cordic_zi), .cordic_strobe_out(cordic_strobe_out),
        .cordic_last_out(cordic_last_out), .cordic_xo(cordic_xo), .cordic_yo(cordic_yo),
        .cordic_zo(cordic_zo), .m_x(m_x), .m_y(m_y), .m_last(m_last), .m_chan(m_chan),
        .m_valid(m_valid), .m_ready(m_ready), .idle(idle)
    );

    // CORDIC stand-in: L enabled stages, results equal the issued x/y.
    logic [L-1:0]  pv, pl;
    logic [BW-1:0] px [L];
    logic [BW-1:0] py [L];
    always @(posedge clk) begin
        if (reset) begin
            pv <= '0;
            pl <= '0;
            for (int i = 0; i < L; i++) begin px[i] <= '0; py[i] <= '0; end
        end else if (cordic_enable) begin
            pv <= {pv[L-2:0], cordic_strobe_in};
            pl <= {pl[L-2:0], cordic_last_in};
            px[0] <= cordic_xi;
            py[0] <= cordic_yi;
            for (int i = 1; i < L; i++) begin px[i] <= px[i-1]; py[i] <= py[i-1]; end
        end
    end
    assign cordic_strobe_out = pv[L-1];
    assign cordic_last_out   = pl[L-1];
    assign cordic_xo         = px[L-1];
    assign cordic_yo         = py[L-1];
    assign cordic_zo         = '0;

    // Per-channel producers: data advances one step per accepted beat.
    logic [BW-1:0] x0 [NUM_CH];
    logic [BW-1:0] y0 [NUM_CH];
    logic [ZW-1:0] z0 [NUM_CH];
    int unsigned   beat     [NUM_CH] = '{0, 0, 0, 0};
    int unsigned   pkt_base [NUM_CH] = '{0, 0, 0, 0};
    int unsigned   pkt_len  [NUM_CH] = '{1, 1, 1, 1};
    logic          adv_v = 1'b0;
    int            adv_ch = 0;

    always_comb begin
        s_x = '0; s_y = '0; s_z = '0; s_last = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_x[c*BW +: BW] = x0[c] + BW'((beat[c] - pkt_base[c]) * 7);
            s_y[c*BW +: BW] = y0[c] + BW'((beat[c] - pkt_base[c]) * 3);
            s_z[c*ZW +: ZW] = z0[c] + ZW'((beat[c] - pkt_base[c]) * 32'h9e37);
            s_last[c] = (((beat[c] - pkt_base[c]) % pkt_len[c]) == pkt_len[c] - 1);
        end
    end

    always @(posedge clk) if (adv_v) beat[adv_ch] <= beat[adv_ch] + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference arbiter, scoreboard and grant log.
    logic [EW-1:0] exp_q [$];
    int            grant_log [$];
    int            ref_ptr = 0, ref_cnt = 0, ref_lock_ch = 0, out_cnt = 0;
    bit            ref_locked = 0, prev_stall = 0;
    logic [EW-1:0] held;

    always @(negedge clk) begin
        bit found, hs, exp_en;
        int g;
        logic [EW-1:0] e;
        if (reset) begin
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_strobe_in", 64'(cordic_strobe_in), 64'd0);
            check("rst_xi", 64'(cordic_xi), 64'd0);
            ref_ptr = 0; ref_cnt = 0; ref_locked = 0; prev_stall = 0; adv_v = 0;
            exp_q.delete();
        end else begin
            exp_en = !(cordic_strobe_out && !m_ready);
            check("enable", 64'(cordic_enable), 64'(exp_en));
            check("idle", 64'(idle), 64'((ref_cnt == 0) && (s_valid == 0)));
            check("m_valid", 64'(m_valid), 64'(cordic_strobe_out));
            if (prev_stall) check("held", 64'({m_chan, m_last, m_x, m_y}), 64'(held));
            found = 0; g = 0;
            if (ref_locked) begin
                found = s_valid[ref_lock_ch]; g = ref_lock_ch;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!found && s_valid[(ref_ptr + k) % NUM_CH]) begin
                        found = 1; g = (ref_ptr + k) % NUM_CH;
                    end
                end
            end
            hs = found && exp_en;
            check("s_ready", 64'(s_ready), hs ? (64'd1 << g) : 64'd0);
            check("strobe_in", 64'(cordic_strobe_in), 64'(hs));
            if (found) begin
                check("xi", 64'(cordic_xi), 64'(s_x[g*BW +: BW]));
                check("zi", 64'(cordic_zi), 64'(s_z[g*ZW +: ZW]));
                check("last_in", 64'(cordic_last_in), 64'(s_last[g]));
            end else begin
                check("xi_idle", 64'(cordic_xi), 64'd0);
            end
            for (int c = 0; c < NUM_CH; c++) if (s_ready[c]) grant_log.push_back(c);
            adv_v = hs;
            if (hs) begin
                exp_q.push_back({CW'(g), s_last[g], s_x[g*BW +: BW], s_y[g*BW +: BW]});
                adv_ch = g;
                ref_cnt++;
`ifdef CORDIC_RR_PKT_LOCK_EN
                if (s_last[g]) begin
                    ref_locked = 0; ref_ptr = (g + 1) % NUM_CH;
                end else begin
                    ref_locked = 1; ref_lock_ch = g;
                end
`else
                ref_ptr = (g + 1) % NUM_CH;
`endif
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_chan", 64'(m_chan), 64'(e[EW-1 -: CW]));
                    check("out_last", 64'(m_last), 64'(e[2*BW]));
                    check("out_x", 64'(m_x), 64'(e[2*BW-1 -: BW]));
                    check("out_y", 64'(m_y), 64'(e[BW-1:0]));
                end
                ref_cnt--;
                out_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            held = {m_chan, m_last, m_x, m_y};
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        step(1);
        check("idle_after_drain", 64'(idle), 64'd1);
    endtask

    function automatic int log_at(input int idx);
        return (idx < grant_log.size()) ? grant_log[idx] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, oc, mv;
        int lock_exp [6];
        for (int c = 0; c < NUM_CH; c++) begin
            x0[c] = BW'(c * 100000 + 5);
            y0[c] = BW'(c * 7000 + 11);
            z0[c] = ZW'(c * 300000 + 17);
        end
        step(3);
        reset = 1'b0;
        check("reset_idle", 64'(idle), 64'd1);
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_s_ready", 64'(s_ready), 64'd0);

        // Single sample on ch0: latency and tagging.
        x0[0] = 24'd1000; y0[0] = 24'd0; z0[0] = 24'd0; pkt_base[0] = beat[0];
        s_valid = 4'b0001;
        step(1);
        s_valid = 4'b0000;
        k = 0;
        while (k < 40 && !m_valid) begin @(negedge clk); k++; end
        check("lat_cycles", 64'(k), 64'd21);
        check("lat_m_x", 64'(m_x), 64'd1000);
        check("lat_m_y", 64'(m_y), 64'd0);
        check("lat_m_chan", 64'(m_chan), 64'd0);
        check("lat_m_last", 64'(m_last), 64'd1);
        step(1);
        check("lat_idle", 64'(idle), 64'd1);

        // All four channels contend.
        do_reset();
        base = grant_log.size();
        s_valid = 4'b1111;
        step(8);
        s_valid = 4'b0000;
        for (int i = 0; i < 8; i++) check("rr_order", 64'(log_at(base + i)), 64'(i % 4));
        wait_drain();

        // Fill the pipeline, then back-pressure for 10 cycles.
        s_valid = 4'b1111;
        step(25);
        m_ready = 1'b0;
        s_valid = 4'b0000;
        oc = out_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_enable", 64'(cordic_enable), 64'd0);
            check("stall_s_ready", 64'(s_ready), 64'd0);
            check("stall_m_valid", 64'(m_valid), 64'd1);
        end
        step(1);
        m_ready = 1'b1;
        wait_drain();
        check("stall_result_count", 64'(out_cnt - oc), 64'd21);

        // Lone requester, then a second one joins.
        base = grant_log.size();
        s_valid = 4'b0100;
        step(30);
        s_valid = 4'b0110;
        step(8);
        s_valid = 4'b0000;
        for (int i = 0; i < 30; i++) check("solo_ch2", 64'(log_at(base + i)), 64'd2);
        for (int i = 0; i < 8; i++)
            check("alt_12", 64'(log_at(base + 30 + i)), (i % 2 == 0) ? 64'd1 : 64'd2);
        wait_drain();

        // Reset with samples in flight.
        s_valid = 4'b1111;
        step(10);
        reset = 1'b1;
        s_valid = 4'b0000;
        step(2);
        reset = 1'b0;
        oc = out_cnt;
        mv = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (m_valid) mv++; end
        check("midrst_m_valid_seen", 64'(mv), 64'd0);
        check("midrst_outputs", 64'(out_cnt - oc), 64'd0);
        check("midrst_idle", 64'(idle), 64'd1);
        base = grant_log.size();
        s_valid = 4'b1010;
        step(1);
        s_valid = 4'b0000;
        check("midrst_first_grant", 64'(log_at(base)), 64'd1);
        wait_drain();

        // ch1 sends a 4-beat packet while ch0 also requests.
        do_reset();
        pkt_base[1] = beat[1]; pkt_len[1] = 4;
        pkt_base[0] = beat[0]; pkt_len[0] = 1;
`ifdef CORDIC_RR_PKT_LOCK_EN
        lock_exp = '{1, 1, 1, 1, 0, 1};
`else
        lock_exp = '{1, 0, 1, 0, 1, 0};
`endif
        base = grant_log.size();
        s_valid = 4'b0010;
        step(1);
        s_valid = 4'b0011;
        step(5);
        s_valid = 4'b0000;
        for (int i = 0; i < 6; i++) check("pkt_order", 64'(log_at(base + i)), 64'(lock_exp[i]));
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
